// File: rtl/sct_seq_pkg.sv
// Shared definitions for the stage sequencer: default sizes, index width
// helper and the sequencer state encoding.
package sct_seq_pkg;

    localparam int unsigned NSTAGE_DEF = 8;
    localparam int unsigned CNTW_DEF   = 4;
    localparam int unsigned IDXW_DEF   = $clog2(NSTAGE_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Index width for n stages, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sct_next_stage.sv
// Combinational priority finder: returns the lowest set mask bit strictly
// above cur_idx (or the lowest set bit overall when from_first is high).
// Ports:
//   mask       - candidate stages
//   cur_idx    - index of the stage currently active
//   from_first - ignore cur_idx and search from bit 0 inclusive
//   nxt_idx    - index found (0 when none)
//   none_found - no qualifying bit exists
module sct_next_stage
    import sct_seq_pkg::*;
#(
    parameter int unsigned NSTAGE = NSTAGE_DEF,
    parameter int unsigned IDXW   = idx_width(NSTAGE)
) (
    input  logic [NSTAGE-1:0] mask,
    input  logic [IDXW-1:0]   cur_idx,
    input  logic              from_first,
    output logic [IDXW-1:0]   nxt_idx,
    output logic              none_found
);

    // Ascending scan; the first hit wins so the result is the lowest index.
    always_comb begin
        nxt_idx    = '0;
        none_found = 1'b1;
        for (int i = 0; i < int'(NSTAGE); i++) begin
            if (none_found && mask[i] && (from_first || (IDXW'(i) > cur_idx))) begin
                nxt_idx    = IDXW'(i);
                none_found = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sct_stage_sequencer.sv
// Stage sequencer: walks the set bits of a captured mask from low to high,
// holding each stage's one-hot enable for (dwell+1) unstalled cycles, then
// signals completion with a single DONE cycle.
// Ports:
//   clock, rst_n - clock and asynchronous active-low reset
//   start        - begin a sequence (IDLE only)
//   abort        - drop the running sequence back to IDLE, no done
//   stall        - freeze dwell counter and current stage
//   mask, dwell  - stages to visit and cycles-per-stage minus one
//   stage_en     - registered one-hot enable of the active stage
//   stage_idx    - registered index of the active stage
//   busy         - high in RUN and DONE
//   done         - one-cycle completion pulse
//   error        - one-cycle pulse for start with an empty mask
module sct_stage_sequencer
    import sct_seq_pkg::*;
#(
    parameter int unsigned NSTAGE = NSTAGE_DEF,
    parameter int unsigned CNTW   = CNTW_DEF
) (
    input  logic                            clock,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            stall,
    input  logic [NSTAGE-1:0]               mask,
    input  logic [CNTW-1:0]                 dwell,
    output logic [NSTAGE-1:0]               stage_en,
    output logic [idx_width(NSTAGE)-1:0]    stage_idx,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam int unsigned IDXW = idx_width(NSTAGE);

    state_e              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [NSTAGE-1:0]   mask_q, mask_d;
    logic [CNTW-1:0]     dwell_q, dwell_d;
    logic [NSTAGE-1:0]   stage_en_q, stage_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic [NSTAGE-1:0]   find_mask_c;
    logic                find_first_c;
    logic [IDXW-1:0]     nxt_idx_c;
    logic                none_found_c;

    // In IDLE search the live mask from bit 0; in RUN search the captured
    // mask above the current stage so no stage is revisited.
    assign find_first_c = (state_q == ST_IDLE);
    assign find_mask_c  = find_first_c ? mask : mask_q;

    sct_next_stage #(
        .NSTAGE (NSTAGE),
        .IDXW   (IDXW)
    ) u_next_stage (
        .mask       (find_mask_c),
        .cur_idx    (idx_q),
        .from_first (find_first_c),
        .nxt_idx    (nxt_idx_c),
        .none_found (none_found_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mask == '0) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        mask_d  = mask;
                        dwell_d = dwell;
                        cnt_d   = dwell;
                        idx_d   = nxt_idx_c;
                    end
                end
            end
            ST_RUN: begin
                // Abort outranks both stall and advance.
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    mask_d  = '0;
                end else if (!stall) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNTW'(1);
                    end else if (none_found_c) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                        mask_d  = '0;
                    end else begin
                        idx_d = nxt_idx_c;
                        cnt_d = dwell_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
                mask_d  = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        stage_en_d = (state_d == ST_RUN) ? (NSTAGE'(1) << idx_d) : '0;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            dwell_q    <= '0;
            stage_en_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            dwell_q    <= dwell_d;
            stage_en_q <= stage_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // idx_q is forced to 0 whenever the sequencer leaves RUN.
    assign stage_idx = idx_q;
    assign stage_en  = stage_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_sct_stage_sequencer.sv
// Directed testbench for sct_stage_sequencer.
module tb_sct_stage_sequencer;

    logic       clock;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       stall;
    logic [7:0] mask;
    logic [3:0] dwell;
    logic [7:0] stage_en;
    logic [2:0] stage_idx;
    logic       busy;
    logic       done;
    logic       error;

    int total = 0;
    int bad   = 0;

    sct_stage_sequencer #(
        .NSTAGE (8),
        .CNTW   (4)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .stall     (stall),
        .mask      (mask),
        .dwell     (dwell),
        .stage_en  (stage_en),
        .stage_idx (stage_idx),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        mask  = 8'h00;
        dwell = 4'd0;
        tick();
        tick();
        total++; if (stage_en !== 8'h00) begin bad++; $display("FAIL reset_en: got %h want 00", stage_en); end
        total++; if (stage_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", stage_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
        rst_n = 1'b1;
        tick();
    endtask

    // mask=05, dwell=1: stage 0 for two cycles, stage 2 for two, DONE, IDLE.
    task automatic test_basic();
        logic [7:0] exp_en   [6];
        logic [2:0] exp_idx  [6];
        logic       exp_busy [6];
        logic       exp_done [6];
        exp_en   = '{8'h01, 8'h01, 8'h04, 8'h04, 8'h00, 8'h00};
        exp_idx  = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        mask  = 8'h05;
        dwell = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++; if (stage_en !== exp_en[i]) begin bad++; $display("FAIL basic_en[%0d]: got %h want %h", i, stage_en, exp_en[i]); end
            total++; if (stage_idx !== exp_idx[i]) begin bad++; $display("FAIL basic_idx[%0d]: got %0d want %0d", i, stage_idx, exp_idx[i]); end
            total++; if (busy !== exp_busy[i]) begin bad++; $display("FAIL basic_busy[%0d]: got %b want %b", i, busy, exp_busy[i]); end
            total++; if (done !== exp_done[i]) begin bad++; $display("FAIL basic_done[%0d]: got %b want %b", i, done, exp_done[i]); end
            tick();
        end
    endtask

    // mask=FF, dwell=0, stall held for three edges while in stage 2.
    task automatic test_stall();
        logic [2:0] exp_idx [13];
        logic [7:0] exp_en;
        exp_idx = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5,
                    3'd6, 3'd7, 3'd0, 3'd0};
        mask  = 8'hFF;
        dwell = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            stall  = (c >= 3 && c <= 5);
            exp_en = (c <= 11) ? (8'h01 << exp_idx[c-1]) : 8'h00;
            total++; if (stage_en !== exp_en) begin bad++; $display("FAIL stall_en[%0d]: got %h want %h", c, stage_en, exp_en); end
            total++; if (stage_idx !== exp_idx[c-1]) begin bad++; $display("FAIL stall_idx[%0d]: got %0d want %0d", c, stage_idx, exp_idx[c-1]); end
            total++; if (busy !== (c <= 12)) begin bad++; $display("FAIL stall_busy[%0d]: got %b want %b", c, busy, (c <= 12)); end
            total++; if (done !== (c == 12)) begin bad++; $display("FAIL stall_done[%0d]: got %b want %b", c, done, (c == 12)); end
            tick();
        end
        stall = 1'b0;
    endtask

    // Empty mask: error pulse only.
    task automatic test_error();
        mask  = 8'h00;
        dwell = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (error !== 1'b1) begin bad++; $display("FAIL err_pulse: got %b want 1", error); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_busy: got %b want 0", busy); end
        total++; if (stage_en !== 8'h00) begin bad++; $display("FAIL err_en: got %h want 00", stage_en); end
        tick();
        total++; if (error !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", error); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_busy2: got %b want 0", busy); end
    endtask

    // mask=90, dwell=3, abort in second cycle of stage 4, then restart.
    task automatic test_abort();
        mask  = 8'h90;
        dwell = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (stage_en !== 8'h10) begin bad++; $display("FAIL abort_en1: got %h want 10", stage_en); end
        tick();
        total++; if (stage_en !== 8'h10) begin bad++; $display("FAIL abort_en2: got %h want 10", stage_en); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (stage_en !== 8'h00) begin bad++; $display("FAIL abort_en3: got %h want 00", stage_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done2: got %b want 0", done); end
        total++; if (stage_en !== 8'h00) begin bad++; $display("FAIL abort_en4: got %h want 00", stage_en); end
        mask  = 8'h05;
        dwell = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (stage_en !== 8'h01) begin bad++; $display("FAIL restart_en0: got %h want 01", stage_en); end
        tick();
        total++; if (stage_en !== 8'h04) begin bad++; $display("FAIL restart_en2: got %h want 04", stage_en); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done: got %b want 1", done); end
        tick();
    endtask

    // mask=80, dwell=15; start re-pulsed and mask/dwell changed mid-run,
    // plus a start in the DONE cycle that must be ignored.
    task automatic test_ignore();
        mask  = 8'h80;
        dwell = 4'd15;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 18; c++) begin
            start = ((c % 3 == 0) && c <= 16) || (c == 17);
            mask  = (c >= 2) ? 8'h01 : 8'h80;
            dwell = (c >= 2) ? 4'd0 : 4'd15;
            total++; if (stage_en !== ((c <= 16) ? 8'h80 : 8'h00)) begin bad++; $display("FAIL ign_en[%0d]: got %h want %h", c, stage_en, ((c <= 16) ? 8'h80 : 8'h00)); end
            total++; if (busy !== (c <= 17)) begin bad++; $display("FAIL ign_busy[%0d]: got %b want %b", c, busy, (c <= 17)); end
            total++; if (done !== (c == 17)) begin bad++; $display("FAIL ign_done[%0d]: got %b want %b", c, done, (c == 17)); end
            tick();
        end
        start = 1'b0;
        tick();
    endtask

    // Asynchronous reset in the middle of RUN, then a normal sequence.
    task automatic test_reset_midrun();
        mask  = 8'h05;
        dwell = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (stage_en !== 8'h01) begin bad++; $display("FAIL rst_pre_en: got %h want 01", stage_en); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (stage_en !== 8'h00) begin bad++; $display("FAIL rst_async_en: got %h want 00", stage_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_async_done: got %b want 0", done); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_hold_done: got %b want 0", done); end
        total++; if (stage_en !== 8'h00) begin bad++; $display("FAIL rst_hold_en: got %h want 00", stage_en); end
        rst_n = 1'b1;
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_error();
        test_abort();
        test_ignore();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
